// File: rtl/core2wb_pipelined.sv
// Ibex-style req/gnt/rvalid port to Wishbone B4 pipelined master, with up to
// MaxOutstanding requests in flight and a watchdog that flushes a hung bus.
module core2wb_pipelined #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MaxOutstanding = 2,
  parameter int TimeoutCycles  = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            core_req,
  output logic            core_gnt,
  input  logic            core_we,
  input  logic [DW/8-1:0] core_be,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW-1:0]   core_wdata,
  output logic            core_rvalid,
  output logic [DW-1:0]   core_rdata,
  output logic            core_err,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_stall_i,
  output logic            timeout_o,
  output logic            spurious_o
);

  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam int TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CW-1:0] MaxCnt  = CW'(MaxOutstanding);
  localparam logic [TW-1:0] WdLimit = TW'(TimeoutCycles);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   wd_q, wd_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            timeout_q, timeout_d;
  logic            spurious_q, spurious_d;
  logic            resp, resp_ok;

  // Request fields go straight through; only stb/cyc/gnt are qualified.
  assign wb_we_o  = core_we;
  assign wb_sel_o = core_be;
  assign wb_adr_o = core_addr;
  assign wb_dat_o = core_wdata;

  assign resp = wb_ack_i | wb_err_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    timeout_d  = 1'b0;
    spurious_d = 1'b0;
    wb_stb_o   = 1'b0;
    wb_cyc_o   = 1'b0;
    core_gnt   = 1'b0;
    resp_ok    = 1'b0;

    unique case (state_q)
      RUN: begin
        wb_stb_o   = core_req && (cnt_q < MaxCnt);
        core_gnt   = wb_stb_o && !wb_stall_i;
        wb_cyc_o   = wb_stb_o || (cnt_q != '0);
        resp_ok    = resp && (cnt_q != '0);
        spurious_d = resp && (cnt_q == '0);

        if (resp_ok) begin
          rvalid_d = 1'b1;
          rdata_d  = wb_dat_i;
          err_d    = wb_err_i;
        end

        if (core_gnt && !resp_ok) begin
          cnt_d = cnt_q + CW'(1);
        end else if (!core_gnt && resp_ok) begin
          cnt_d = cnt_q - CW'(1);
        end

        // Watchdog counts silent cycles while anything is outstanding.
        if ((cnt_q == '0) || resp_ok) begin
          wd_d = '0;
        end else if (TimeoutCycles != 0) begin
          wd_d = wd_q + TW'(1);
          if (wd_d == WdLimit) begin
            wd_d      = '0;
            timeout_d = 1'b1;
            state_d   = FLUSH;
          end
        end
      end

      FLUSH: begin
        wd_d = '0;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          cnt_d    = cnt_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      wd_q       <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      spurious_q <= spurious_d;
    end
  end

  assign core_rvalid = rvalid_q;
  assign core_rdata  = rdata_q;
  assign core_err    = err_q;
  assign timeout_o   = timeout_q;
  assign spurious_o  = spurious_q;

endmodule
